// File: rtl/jt1943_romarb.sv
// rtl/jt1943_romarb.sv - SDRAM read arbiter for four ROM ports with periodic autorefresh
module jt1943_romarb #(
    parameter int AW             = 22,
    parameter int DW             = 32,
    parameter int REFRESH_PERIOD = 1024,
    parameter int TIMEOUT        = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            downloading,
    input  logic [3:0]      req,
    input  logic [4*AW-1:0] addr,
    output logic [3:0]      ack,
    output logic [DW-1:0]   dout,
    output logic            sdram_re,
    output logic [AW-1:0]   sdram_addr,
    input  logic            sdram_rdy,
    input  logic [DW-1:0]   data_read,
    output logic            refresh,
    input  logic            refresh_done,
    output logic            timeout_err
);

    localparam int RW = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_REFRESH
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    rr;          // first of ports 1-3 to consider next
    logic [1:0]    gnt;         // port owning the current read
    logic [TW-1:0] wait_cnt;
    logic [RW-1:0] ref_cnt;
    logic          ref_pend;
    logic [1:0]    win_port;
    logic          win_valid;
    logic          go_grant;
    logic          go_refresh;
    logic          rd_done;
    logic          rd_timeout;

    // Port 0 always wins; otherwise search ports 1-3 starting at the round-robin pointer
    always_comb begin : arb
        logic [1:0] p;
        win_valid = 1'b0;
        win_port  = 2'd0;
        p         = rr;
        if (req[0]) begin
            win_valid = 1'b1;
            win_port  = 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!win_valid && req[p]) begin
                    win_valid = 1'b1;
                    win_port  = p;
                end
                p = (p == 2'd3) ? 2'd1 : p + 2'd1;
            end
        end
    end

    // Next state; a port being acked this cycle is not re-granted until the following cycle
    always_comb begin
        state_nx   = state;
        go_grant   = 1'b0;
        go_refresh = 1'b0;
        rd_done    = 1'b0;
        rd_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!downloading && ref_pend) begin
                    go_refresh = 1'b1;
                    state_nx   = ST_REFRESH;
                end else if (!downloading && win_valid && !ack[win_port]) begin
                    go_grant = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (sdram_rdy) begin
                    rd_done  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (wait_cnt == TO_LAST) begin
                    rd_timeout = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                if (refresh_done) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign refresh = go_refresh;

    // Transaction state: grant latch, read strobe, data/ack return and timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr          <= 2'd1;
            gnt         <= 2'd0;
            sdram_re    <= 1'b0;
            sdram_addr  <= '0;
            ack         <= 4'b0000;
            dout        <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nx;
            sdram_re <= go_grant;
            ack      <= rd_done ? (4'b0001 << gnt) : 4'b0000;
            if (go_grant) begin
                gnt        <= win_port;
                sdram_addr <= addr[win_port*AW +: AW];
                if (win_port != 2'd0)
                    rr <= (win_port == 2'd3) ? 2'd1 : win_port + 2'd1;
            end
            if (rd_done)
                dout <= data_read;
            if (rd_timeout)
                timeout_err <= 1'b1;
            if (state == ST_ISSUE)
                wait_cnt <= '0;
            else if (state == ST_WAIT)
                wait_cnt <= wait_cnt + TW'(1);
        end
    end

    // Refresh timer; a single pending flag so repeated expiries never stack up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else if (downloading) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + RW'(1);
            if (go_refresh)
                ref_pend <= 1'b0;
            else if (ref_cnt == REF_LAST)
                ref_pend <= 1'b1;
        end
    end

endmodule
